e_finder_param: RTL and testbench
=================================

Name: e_finder_param

Overview:
- Parametrised successor to the fixed-width exponent finder for the Pollard p-1 datapath.
- Computes E = lcm(1..B), i.e. the product over primes p<=B of p^floor(log_p B), with a start/busy/done handshake.
- Adds configurable widths, overflow detection and restart.
- Feeds the modular-exponentiation stage, which computes a^E mod N.

Parameters:
- BOUND_W, 8, width of the boundary input B
- E_W, 65, width of the exponent result E

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request; samples boundary
- boundary  input  BOUND_W  smoothness bound B (unsigned)
- busy  output  1  high while computing
- done  output  1  level; result valid; cleared by the next accepted start
- overflow  output  1  valid with done; E did not fit in E_W bits
- e  output  E_W  result; holds last value until the next accepted start

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, overflow=0, e=1. Internal k, d, r cleared.
- Reset asserted mid-computation aborts immediately; no partial result is flagged done.
- start is accepted only in IDLE or DONE.
  - On acceptance: latch B, set e=1, k=2, busy=1, done=0, overflow=0.
  - start while busy is ignored.
- FSM states:
  - IDLE/DONE: wait for start.
  - NEXT_K: if k>B go to DONE. Otherwise set d=2, r=k, go to FIND_DIV.
  - FIND_DIV (one trial divisor per cycle):
    - if d*d>k: d=k (k is prime), go to STRIP.
    - else if k%d==0: go to STRIP.
    - else d=d+1.
  - STRIP (one division per cycle): while r%d==0, r=r/d. When r%d!=0 or r==1, test r.
    - r==1: k is a power of d; go to MUL.
    - otherwise: k=k+1, go to NEXT_K.
  - MUL: compute e*d at full E_W+BOUND_W width.
    - If the high bits are nonzero: overflow=1, keep e unchanged, go to DONE (early abort).
    - Else: e=e*d[E_W-1:0], k=k+1, go to NEXT_K.
  - DONE: busy=0, done=1.
- Counter widths:
  - k, d and r are BOUND_W+1 bits, so k=B+1 does not wrap when B = 2^BOUND_W - 1.
  - d*d is computed at 2*(BOUND_W+1) bits.
- Boundary conditions:
  - B=0 or B=1: done with e=1, overflow=0, two cycles after start.
  - B=2: e=2.
- Latency:
  - Data-dependent; O(B*sqrt(B)) cycles.
  - Bench timeout is B*B+16 cycles.
- Division and modulo are combinational on BOUND_W+1-bit operands. Only the multiply touches E_W bits.

Optional Feature:
- Macro: E_FINDER_STATS_EN
- Defined:
  - Adds output mul_count [BOUND_W-1:0], the number of MUL steps performed.
  - Adds output cycle_count [31:0], cycles from the accepted start to done, saturating at all-ones.
  - Both counters clear on reset and on an accepted start, and hold while done.
- Undefined: the ports and counters do not exist; core behaviour is identical.

Decomposition:
- Package e_finder_pkg: FSM state enum (IDLE, NEXT_K, FIND_DIV, STRIP, MUL, DONE), default BOUND_W/E_W constants, and a function giving the bench timeout bound.
- One sub-module, pp_detector: owns the k/d/r registers and the FIND_DIV/STRIP sequencing; returns is_prime_power and base d with a valid pulse.
- Top level keeps the handshake, the E register, the multiply and the overflow logic.

Test Plan:
- Reset then start with B=10 (defaults) -> done=1, e=2520, overflow=0; busy high from the cycle after start until done.
- B=20 -> e=232792560. B=0 and B=1 -> e=1 within 2 cycles of start.
- E_W=32: B=22 -> e=232792560, overflow=0. B=23 -> overflow=1, done=1, e=232792560 (value held before the failing multiply).
- E_W=144, B=100 -> e=69720375229712477164533808935312303556800, overflow=0.
- start pulsed while busy (B=50 then B=10) -> ignored; final e=lcm(1..50)=3099044504245996706400, overflow=0 with E_W=144.
- rst_n dropped mid-run (B=100) -> next cycle busy=0, done=0, e=1; a fresh start with B=10 gives 2520.
- With E_FINDER_STATS_EN, B=10 -> mul_count=7 (k=2,3,4,5,7,8,9).

Source files
------------

// File: rtl/e_finder_pkg.sv
// rtl/e_finder_pkg.sv - shared FSM states, default widths and bench timeout helper for e_finder_param
package e_finder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    NEXT_K,
    FIND_DIV,
    STRIP,
    MUL,
    DONE
  } state_t;

  localparam int BOUND_W_DEF = 8;
  localparam int E_W_DEF     = 65;

  function automatic int timeout_bound(input int b);
    return b * b + 16;
  endfunction

endpackage

// File: rtl/e_finder_param_pp_detector.sv
// rtl/e_finder_param_pp_detector.sv - walks k=2..B and reports whether k is a power of a prime base d
module pp_detector
  import e_finder_pkg::*;
#(
  parameter int BOUND_W = BOUND_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               init,
  input  logic [BOUND_W-1:0] boundary,
  input  state_t             state,
  input  logic               k_inc,
  output logic               k_over,
  output logic               div_found,
  output logic               valid,
  output logic               is_pp,
  output logic [BOUND_W:0]   base
);

  localparam int CW = BOUND_W + 1;

  logic [CW-1:0]   k, d, r, b_q;
  logic [CW-1:0]   d_safe, k_mod, r_mod, r_div;
  logic [2*CW-1:0] d_sq, k_ext;
  logic            d_past_root;

  // d is only zero outside FIND_DIV/STRIP; the guard keeps the dividers well defined
  always_comb begin
    d_safe      = (d == '0) ? CW'(1) : d;
    k_mod       = k % d_safe;
    r_mod       = r % d_safe;
    r_div       = r / d_safe;
    d_sq        = {{CW{1'b0}}, d} * {{CW{1'b0}}, d};
    k_ext       = {{CW{1'b0}}, k};
    d_past_root = d_sq > k_ext;
    k_over      = k > b_q;
    div_found   = (state == FIND_DIV) && (d_past_root || (k_mod == '0));
    valid       = (state == STRIP) && ((r == CW'(1)) || (r_mod != '0));
    is_pp       = (r == CW'(1));
    base        = d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k   <= '0;
      d   <= '0;
      r   <= '0;
      b_q <= '0;
    end else if (init) begin
      k   <= CW'(2);
      b_q <= {1'b0, boundary};
    end else begin
      if (k_inc) k <= k + CW'(1);
      case (state)
        NEXT_K: begin
          if (!k_over) begin
            d <= CW'(2);
            r <= k;
          end
        end
        FIND_DIV: begin
          if (d_past_root)       d <= k;
          else if (k_mod != '0)  d <= d + CW'(1);
        end
        STRIP: begin
          if (!valid) r <= r_div;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/e_finder_param.sv
// rtl/e_finder_param.sv - E = lcm(1..B) with start/busy/done handshake; E_FINDER_STATS_EN adds mul/cycle counters
module e_finder_param
  import e_finder_pkg::*;
#(
  parameter int BOUND_W = BOUND_W_DEF,
  parameter int E_W     = E_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [BOUND_W-1:0] boundary,
  output logic               busy,
  output logic               done,
  output logic               overflow,
  output logic [E_W-1:0]     e
`ifdef E_FINDER_STATS_EN
  ,
  output logic [BOUND_W-1:0] mul_count,
  output logic [31:0]        cycle_count
`endif
);

  localparam int PW = E_W + BOUND_W + 1;

  state_t           state, state_nxt;
  logic             accept, k_inc, mul_ovf;
  logic             k_over, div_found, valid, is_pp;
  logic [BOUND_W:0] base;
  logic [PW-1:0]    prod;

  pp_detector #(.BOUND_W(BOUND_W)) u_pp (
    .clk       (clk),
    .rst_n     (rst_n),
    .init      (accept),
    .boundary  (boundary),
    .state     (state),
    .k_inc     (k_inc),
    .k_over    (k_over),
    .div_found (div_found),
    .valid     (valid),
    .is_pp     (is_pp),
    .base      (base)
  );

  // base never exceeds B, so any bit at or above E_W means E no longer fits
  always_comb begin
    prod    = {{(BOUND_W + 1){1'b0}}, e} * {{E_W{1'b0}}, base};
    mul_ovf = |prod[PW-1:E_W];
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    k_inc     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = NEXT_K;
        end
      end
      NEXT_K:   state_nxt = k_over ? DONE : FIND_DIV;
      FIND_DIV: if (div_found) state_nxt = STRIP;
      STRIP: begin
        if (valid) begin
          state_nxt = is_pp ? MUL : NEXT_K;
          k_inc     = !is_pp;
        end
      end
      MUL: begin
        state_nxt = mul_ovf ? DONE : NEXT_K;
        k_inc     = !mul_ovf;
      end
      default: state_nxt = IDLE;
    endcase
    busy = (state == NEXT_K) || (state == FIND_DIV) || (state == STRIP) || (state == MUL);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      e        <= E_W'(1);
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        e        <= E_W'(1);
        overflow <= 1'b0;
      end else if (state == MUL) begin
        if (mul_ovf) overflow <= 1'b1;
        else         e        <= prod[E_W-1:0];
      end
    end
  end

`ifdef E_FINDER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_count   <= '0;
      cycle_count <= '0;
    end else if (accept) begin
      mul_count   <= '0;
      cycle_count <= '0;
    end else begin
      if (state == MUL)               mul_count   <= mul_count + BOUND_W'(1);
      if (busy && cycle_count != '1)  cycle_count <= cycle_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_e_finder_param.sv
// tb/tb_e_finder_param.sv - scoreboard bench driving three widths of e_finder_param with shared stimulus
module tb_e_finder_param;
  import e_finder_pkg::*;

  typedef struct {
    int           dut;
    logic [143:0] e;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [7:0]   boundary = '0;
  logic         busy0, done0, ov0, busy1, done1, ov1, busy2, done2, ov2;
  logic [64:0]  e0;
  logic [31:0]  e1;
  logic [143:0] e2;
`ifdef E_FINDER_STATS_EN
  logic [7:0]   mc0, mc1, mc2;
  logic [31:0]  cc0, cc1, cc2;
`endif

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   busy_cycles0;

  always #5 clk = ~clk;

  e_finder_param #(.BOUND_W(8), .E_W(65)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .boundary(boundary),
    .busy(busy0), .done(done0), .overflow(ov0), .e(e0)
`ifdef E_FINDER_STATS_EN
    , .mul_count(mc0), .cycle_count(cc0)
`endif
  );
  e_finder_param #(.BOUND_W(8), .E_W(32)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .boundary(boundary),
    .busy(busy1), .done(done1), .overflow(ov1), .e(e1)
`ifdef E_FINDER_STATS_EN
    , .mul_count(mc1), .cycle_count(cc1)
`endif
  );
  e_finder_param #(.BOUND_W(8), .E_W(144)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .boundary(boundary),
    .busy(busy2), .done(done2), .overflow(ov2), .e(e2)
`ifdef E_FINDER_STATS_EN
    , .mul_count(mc2), .cycle_count(cc2)
`endif
  );

  task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] gcd(input logic [255:0] a_in, input logic [255:0] b_in);
    logic [255:0] a, b, t;
    a = a_in;
    b = b_in;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // lcm built by gcd, stopping at the first k whose lcm no longer fits ew bits
  task automatic model(input int b, input int ew, output logic [143:0] e, output logic ovf);
    logic [255:0] cur, nxt;
    cur = 256'd1;
    ovf = 1'b0;
    for (int k = 2; k <= b; k++) begin
      if (!ovf) begin
        nxt = (cur / gcd(cur, 256'(k))) * 256'(k);
        if ((nxt >> ew) != 0) ovf = 1'b1;
        else                  cur = nxt;
      end
    end
    e = cur[143:0];
  endtask

  task automatic push_expect(input int b);
    exp_t x;
    int   widths[3];
    widths = '{65, 32, 144};
    for (int i = 0; i < 3; i++) begin
      x.dut = i;
      model(b, widths[i], x.e, x.ovf);
      sb.push_back(x);
    end
  endtask

  task automatic do_start(input int b, input bit expect_it);
    @(negedge clk);
    start = 1'b1;
    boundary = 8'(b);
    if (expect_it) push_expect(b);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int b, input string tag);
    int  bound;
    bit  all_done, busy_ok;
    bound = timeout_bound(b);
    busy_ok = 1'b1;
    busy_cycles0 = 0;
    all_done = done0 && done1 && done2;
    for (int c = 0; c < bound && !all_done; c++) begin
      if (busy0) busy_cycles0++;
      if (!done2 && !busy2) busy_ok = 1'b0;
      @(negedge clk);
      all_done = done0 && done1 && done2;
    end
    chk($sformatf("%s_done_in_time", tag), 144'(all_done), 144'd1);
    chk($sformatf("%s_busy_until_done", tag), 144'(busy_ok), 144'd1);
  endtask

  task automatic check_results(input string tag);
    exp_t         x;
    logic [143:0] oe;
    logic         oo, od;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      case (x.dut)
        0:       begin oe = 144'(e0); oo = ov0; od = done0; end
        1:       begin oe = 144'(e1); oo = ov1; od = done1; end
        default: begin oe = e2;       oo = ov2; od = done2; end
      endcase
      chk($sformatf("%s_d%0d_e", tag, x.dut), oe, x.e);
      chk($sformatf("%s_d%0d_ovf", tag, x.dut), 144'(oo), 144'(x.ovf));
      chk($sformatf("%s_d%0d_done", tag, x.dut), 144'(od), 144'd1);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", 144'({busy0, busy1, busy2}), 144'd0);
    chk("rst_done", 144'({done0, done1, done2}), 144'd0);
    chk("rst_ovf", 144'({ov0, ov1, ov2}), 144'd0);
    chk("rst_e0", 144'(e0), 144'd1);
    chk("rst_e2", e2, 144'd1);
    rst_n = 1'b1;

    do_start(10, 1'b1);
    chk("b10_busy_after_start", 144'({busy0, busy1, busy2}), 144'b111);
    chk("b10_done_low", 144'(done0), 144'd0);
    wait_done(10, "b10");
    chk("b10_e_literal", 144'(e0), 144'd2520);
`ifdef E_FINDER_STATS_EN
    chk("b10_mul_count", 144'(mc0), 144'd7);
    chk("b10_cycle_count", 144'(cc0), 144'(busy_cycles0));
`endif
    check_results("b10");

    do_start(20, 1'b1);
    wait_done(20, "b20");
    chk("b20_e_literal", 144'(e0), 144'd232792560);
    check_results("b20");

    for (int b = 0; b < 2; b++) begin
      do_start(b, 1'b1);
      @(negedge clk);
      chk($sformatf("b%0d_done_2cyc", b), 144'({done0, done1, done2}), 144'b111);
      check_results($sformatf("b%0d", b));
    end

    do_start(2, 1'b1);
    wait_done(2, "b2");
    chk("b2_e_literal", 144'(e0), 144'd2);
    check_results("b2");

    do_start(22, 1'b1);
    wait_done(22, "b22");
    chk("b22_e32_literal", 144'(e1), 144'd232792560);
    chk("b22_ovf32", 144'(ov1), 144'd0);
    check_results("b22");

    do_start(23, 1'b1);
    wait_done(23, "b23");
    chk("b23_e32_held", 144'(e1), 144'd232792560);
    chk("b23_ovf32", 144'(ov1), 144'd1);
    check_results("b23");

    do_start(100, 1'b1);
    wait_done(100, "b100");
    check_results("b100");

    do_start(50, 1'b1);
    repeat (5) @(negedge clk);
    do_start(10, 1'b0);
    wait_done(50, "b50");
    check_results("b50_ignored_start");

    do_start(100, 1'b0);
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 144'({busy0, busy1, busy2}), 144'd0);
    chk("midrst_done", 144'({done0, done1, done2}), 144'd0);
    chk("midrst_e2", e2, 144'd1);
    @(negedge clk);
    chk("midrst_hold_done", 144'({done0, done1, done2}), 144'd0);
    rst_n = 1'b1;
    do_start(10, 1'b1);
    wait_done(10, "after_rst");
    chk("after_rst_e_literal", 144'(e0), 144'd2520);
    check_results("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
